// File: rtl/arith_unit.sv
// arith_unit: shared arithmetic resource for the differentiator datapath.
//   - Iterative shift-add multiplier. It takes WIDTH steps per product and
//     uses a start/busy/done handshake.
//   - Registered adder/subtractor with a latency of one cycle. Results are
//     valid when as_done is high.
// Ports:
//   clk, reset (async, active-low)
//   mul_start, mul_in1, mul_in2 -> mul_out, mul_ovf, mul_busy, mul_done
//   as_start, as_in1, as_in2, add_sub -> as_out, as_carry, as_done
// All outputs come straight from flops.
module arith_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mul_start,
  input  logic [WIDTH-1:0] mul_in1,
  input  logic [WIDTH-1:0] mul_in2,
  output logic [WIDTH-1:0] mul_out,
  output logic             mul_ovf,
  output logic             mul_busy,
  output logic             mul_done,
  input  logic             as_start,
  input  logic [WIDTH-1:0] as_in1,
  input  logic [WIDTH-1:0] as_in2,
  input  logic             add_sub,
  output logic [WIDTH-1:0] as_out,
  output logic             as_carry,
  output logic             as_done
);

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  // ---------------- multiplier ----------------
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [WIDTH-1:0]   mplier_q, mplier_d, mul_out_q, mul_out_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d, mul_ovf_q, mul_ovf_d, mul_done_q, mul_done_d;

  // Partial product for the current step. The final step's sum is also the
  // completed product, so the result is taken from here on the last edge.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    mul_out_d  = mul_out_q;
    mul_ovf_d  = mul_ovf_q;
    mul_done_d = 1'b0;
    if (!busy_q) begin
      // A start while busy is simply not looked at.
      if (mul_start) begin
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, mul_in1};
        mplier_d = mul_in2;
        cnt_d    = '0;
        busy_d   = 1'b1;
      end
    end else begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        busy_d     = 1'b0;
        mul_out_d  = acc_step[WIDTH-1:0];
        mul_ovf_d  = |acc_step[2*WIDTH-1:WIDTH];
        mul_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      mul_out_q  <= '0;
      mul_ovf_q  <= 1'b0;
      mul_done_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      mul_out_q  <= mul_out_d;
      mul_ovf_q  <= mul_ovf_d;
      mul_done_q <= mul_done_d;
    end
  end

  assign mul_out  = mul_out_q;
  assign mul_ovf  = mul_ovf_q;
  assign mul_busy = busy_q;
  assign mul_done = mul_done_q;

  // ---------------- adder / subtractor ----------------
  logic [WIDTH:0]   sum_ext, dif_ext;
  logic [WIDTH-1:0] as_out_q, as_out_d;
  logic             as_carry_q, as_carry_d, as_done_q, as_done_d;

  // With one extra bit, the top bit of the sum is the carry. The same bit of
  // the difference is the borrow, which is 1 when A < B.
  assign sum_ext = {1'b0, as_in1} + {1'b0, as_in2};
  assign dif_ext = {1'b0, as_in1} - {1'b0, as_in2};

  always_comb begin
    as_out_d   = as_out_q;
    as_carry_d = as_carry_q;
    as_done_d  = as_start;
    if (as_start) begin
      as_out_d   = add_sub ? dif_ext[WIDTH-1:0] : sum_ext[WIDTH-1:0];
      as_carry_d = add_sub ? dif_ext[WIDTH]     : sum_ext[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      as_out_q   <= '0;
      as_carry_q <= 1'b0;
      as_done_q  <= 1'b0;
    end else begin
      as_out_q   <= as_out_d;
      as_carry_q <= as_carry_d;
      as_done_q  <= as_done_d;
    end
  end

  assign as_out   = as_out_q;
  assign as_carry = as_carry_q;
  assign as_done  = as_done_q;

endmodule

// File: tb/tb_arith_unit.sv
// Self-checking bench for arith_unit. Random and directed operands are
// checked against plain integer arithmetic.
module tb_arith_unit;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         mul_start, as_start, add_sub;
  logic [W-1:0] mul_in1, mul_in2, as_in1, as_in2;
  logic [W-1:0] mul_out, as_out;
  logic         mul_ovf, mul_busy, mul_done, as_carry, as_done;

  arith_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .mul_start(mul_start), .mul_in1(mul_in1), .mul_in2(mul_in2),
    .mul_out(mul_out), .mul_ovf(mul_ovf), .mul_busy(mul_busy), .mul_done(mul_done),
    .as_start(as_start), .as_in1(as_in1), .as_in2(as_in2), .add_sub(add_sub),
    .as_out(as_out), .as_carry(as_carry), .as_done(as_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] last_mul_out = '0, last_as_out = '0;
  logic         last_mul_ovf = 1'b0, last_as_carry = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Reference model: {carry/borrow, result} from integer arithmetic.
  function automatic logic [W:0] as_model(input logic [W-1:0] a, b, input logic s);
    longint ai, bi, r;
    ai = longint'(a); bi = longint'(b);
    if (!s) r = ai + bi;
    else    r = ai - bi;
    as_model[W]     = s ? (ai < bi) : (r >= (64'd1 << W));
    as_model[W-1:0] = W'(r & ((64'd1 << W) - 1));
  endfunction

  // Drive one add/sub. as_start is left high so that calls can run back to back.
  task automatic as_op(input logic [W-1:0] a, b, input logic s);
    logic [W:0] e;
    e = as_model(a, b, s);
    as_in1 = a; as_in2 = b; add_sub = s; as_start = 1'b1;
    tick;
    check("as_done", as_done, 1);
    check("as_out", as_out, e[W-1:0]);
    check("as_carry", as_carry, e[W]);
    last_as_out = e[W-1:0]; last_as_carry = e[W];
  endtask

  task automatic as_idle;
    as_start = 1'b0;
    as_in1 = W'($urandom); as_in2 = W'($urandom);
    tick;
    check("as_done_low", as_done, 0);
    check("as_out_hold", as_out, last_as_out);
    check("as_carry_hold", as_carry, last_as_carry);
  endtask

  // One multiply. glitch: re-pulse start with other operands while busy.
  // conc: run random add/sub operations on every cycle of the multiply.
  task automatic run_mul(input logic [W-1:0] a, b, input bit glitch, input bit conc);
    logic [63:0] p;
    logic [W:0]  e;
    int  lat;
    bit  seen;
    p = 64'(a) * 64'(b);
    mul_in1 = a; mul_in2 = b; mul_start = 1'b1;
    tick;
    mul_start = 1'b0;
    check("mul_busy_up", mul_busy, 1);
    check("mul_done_pulse", mul_done, 0);
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= W + 4 && !seen; i++) begin
      if (glitch && i == 5) begin
        mul_in1 = ~a; mul_in2 = b ^ 16'h5a5a; mul_start = 1'b1;
      end
      if (conc) begin
        as_in1 = W'($urandom); as_in2 = W'($urandom); add_sub = 1'($urandom);
        as_start = 1'b1;
        e = as_model(as_in1, as_in2, add_sub);
      end
      tick;
      mul_start = 1'b0;
      if (conc) begin
        check("conc_as_out", {as_carry, as_out}, e);
        last_as_out = e[W-1:0]; last_as_carry = e[W];
      end
      if (i == 3) begin
        check("mul_out_hold", mul_out, last_mul_out);
        check("mul_ovf_hold", mul_ovf, last_mul_ovf);
      end
      if (mul_done) begin seen = 1'b1; lat = i; end
    end
    if (conc) as_start = 1'b0;
    check("mul_done_seen", seen, 1);
    check("mul_latency", lat, W);
    check("mul_out", mul_out, p[W-1:0]);
    check("mul_ovf", mul_ovf, (p >> W) != 0);
    check("mul_busy_dn", mul_busy, 0);
    last_mul_out = p[W-1:0];
    last_mul_ovf = (p >> W) != 0;
  endtask

  initial begin
    bit seen;
    reset = 1'b0; mul_start = 0; as_start = 0; add_sub = 0;
    mul_in1 = '0; mul_in2 = '0; as_in1 = '0; as_in2 = '0;
    tick; tick;
    check("rst_mul_out", mul_out, 0);
    check("rst_flags", {mul_ovf, mul_busy, mul_done, as_carry, as_done}, 0);
    check("rst_as_out", as_out, 0);
    reset = 1'b1;
    tick;

    // Directed multiplies; each one starts the cycle after the previous done.
    run_mul(16'd3, 16'd5, 0, 0);
    run_mul(16'h0100, 16'h0100, 0, 0);
    run_mul(16'hFFFF, 16'h0001, 0, 0);
    run_mul(16'h1234, 16'h0042, 1, 0);
    run_mul(16'h0000, 16'hBEEF, 0, 0);
    run_mul(16'hFFFF, 16'hFFFF, 0, 0);
    run_mul(W'($urandom), W'($urandom), 0, 1);
    tick;

    // Directed add/sub.
    as_op(16'd7, 16'd9, 0);
    as_idle;
    as_op(16'hFFFF, 16'd2, 0);
    as_op(16'd5, 16'd7, 1);
    as_op(16'd9, 16'd4, 1);
    as_op(16'd4, 16'd4, 1);
    as_idle;

    // Random add/sub with start held high, plus occasional idle cycles.
    for (int k = 0; k < 30; k++) begin
      as_op(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 5) == 0) as_idle;
    end
    as_idle;

    // Random multiplies. Half use small operands so no-overflow results are common.
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) run_mul(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 0, k % 4 == 0);
      else            run_mul(W'($urandom), W'($urandom), k == 5, 1);
    end

    // Reset asserted in the middle of a multiply.
    mul_in1 = 16'h00AB; mul_in2 = 16'h00CD; mul_start = 1'b1;
    as_in1 = 16'd1; as_in2 = 16'd2; add_sub = 0; as_start = 1'b1;
    tick;
    mul_start = 1'b0; as_start = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    #2 reset = 1'b0;
    #1;
    check("midrst_mul_out", mul_out, 0);
    check("midrst_flags", {mul_ovf, mul_busy, mul_done, as_carry, as_done}, 0);
    check("midrst_as_out", as_out, 0);
    tick;
    #2 reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      tick;
      if (mul_done || mul_busy) seen = 1'b1;
    end
    check("no_done_after_rst", seen, 0);
    last_mul_out = '0; last_mul_ovf = 1'b0;
    run_mul(16'd3, 16'd5, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got stalled expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/arith_unit.md
Name: arith_unit

Overview:
- Shared arithmetic resource for the differentiator datapath.
- Contains one iterative shift-add multiplier and one registered adder/subtractor, each with its own start/done handshake.
- The datapath controller launches operations and waits on the done flags before latching results into its temporaries.

Parameters:
- WIDTH, 16, operand and result width for both units (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- mul_start  input  1  launch a multiply; sampled on the rising edge.
- mul_in1  input  WIDTH  multiplicand, unsigned.
- mul_in2  input  WIDTH  multiplier, unsigned.
- mul_out  output  WIDTH  low WIDTH bits of the product.
- mul_ovf  output  1  product did not fit in WIDTH bits.
- mul_busy  output  1  multiply in progress.
- mul_done  output  1  one-cycle pulse: mul_out/mul_ovf are valid.
- as_start  input  1  launch an add/subtract; sampled on the rising edge.
- as_in1  input  WIDTH  operand A, unsigned.
- as_in2  input  WIDTH  operand B, unsigned.
- add_sub  input  1  0 = A+B, 1 = A-B.
- as_out  output  WIDTH  result modulo 2^WIDTH.
- as_carry  output  1  add: carry out; subtract: borrow (1 when A<B).
- as_done  output  1  one-cycle pulse: as_out/as_carry are valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0: mul_out, mul_ovf, mul_busy, mul_done, as_out, as_carry, as_done.
  - Internal accumulator, shifted multiplicand, captured multiplier and counter are cleared.
  - Reset asserted mid-multiply aborts the operation; no done pulse follows release.
- Multiplier, start:
  - On a rising edge with mul_start=1 and mul_busy=0: capture mul_in1/mul_in2, clear the 2*WIDTH accumulator and the counter, set mul_busy=1.
  - mul_start while mul_busy=1 is ignored; captured operands are unaffected.
- Multiplier, iteration:
  - One step per clock while busy: if the current multiplier LSB is 1, add the shifted multiplicand to the accumulator; then shift multiplicand left 1 and multiplier right 1; increment counter.
  - After exactly WIDTH steps (the WIDTH-th edge after the start edge), on the same edge:
    - mul_out = accumulator[WIDTH-1:0];
    - mul_ovf = OR of accumulator[2*WIDTH-1:WIDTH];
    - mul_busy = 0;
    - mul_done = 1 for one cycle.
  - Latency is fixed at WIDTH cycles regardless of operand values, including zero operands.
- Multiplier, hold and back-to-back:
  - mul_out and mul_ovf hold until the next completion. They do not change during a following operation.
  - A new mul_start is accepted the cycle after mul_done (mul_busy is already 0). Back-to-back throughput is WIDTH+1 cycles.
- Adder/subtractor:
  - On a rising edge with as_start=1: as_out = (as_in1 ± as_in2) mod 2^WIDTH, with as_carry set as defined above, and as_done=1 for that cycle.
  - Latency is 1 cycle; a new operation may start every cycle. With as_start held high, as_done stays high and the result updates every edge.
  - With as_start=0, as_done returns to 0 and as_out/as_carry hold.
- The two units are fully independent; simultaneous starts on both are allowed.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset low mid-operation, then release → all outputs 0, mul_busy=0; no mul_done pulse afterwards.
- mul_in1=3, mul_in2=5, pulse mul_start → mul_busy high 16 cycles; mul_done pulses on the 16th edge; mul_out=15, mul_ovf=0.
- mul_in1=0x0100, mul_in2=0x0100 → mul_out=0x0000, mul_ovf=1; then 0xFFFF*0x0001 → mul_out=0xFFFF, mul_ovf=0.
- Pulse mul_start again at cycle 5 of a busy multiply with different operands → ignored; original result delivered on schedule; next start accepted the cycle after mul_done.
- add_sub=0, as_in1=7, as_in2=9, as_start one cycle → next edge as_out=16, as_carry=0, as_done one cycle. 0xFFFF+2 → as_out=1, as_carry=1.
- add_sub=1, as_in1=5, as_in2=7 → as_out=0xFFFE, as_carry=1; 9-4 → as_out=5, as_carry=0. Concurrent multiply unaffected.
